// File: rtl/fault_sweep_seq.sv
// Exhaustive stuck-at fault-sweep sequencer: drives every pattern to a good and a faulty CUT copy per fault entry.
// Optional FAULT_SA1_EN appends a stuck-at-1 pass after the stuck-at-0 pass.
module fault_sweep_seq #(
  parameter  int unsigned N_IN    = 4,
  parameter  int unsigned N_OUT   = 1,
  parameter  int unsigned N_FAULT = 1,
  localparam int unsigned IW      = ($clog2(2*N_FAULT) > 0) ? $clog2(2*N_FAULT) : 1,
  localparam int unsigned DW      = $clog2(2*N_FAULT+1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               drop_en,
  output logic [N_IN-1:0]    pat,
  output logic [N_FAULT-1:0] fault_sa0,
  output logic [N_FAULT-1:0] fault_sa1,
  input  logic [N_OUT-1:0]   z_good,
  input  logic [N_OUT-1:0]   z_fault,
  output logic               busy,
  output logic               done,
  output logic [DW-1:0]      det_count,
  input  logic [IW-1:0]      rd_idx,
  output logic               rd_det,
  output logic [N_IN-1:0]    rd_pat
);

`ifdef FAULT_SA1_EN
  localparam int unsigned NF = 2*N_FAULT;
`else
  localparam int unsigned NF = N_FAULT;
`endif
  // Result storage spans the full index space so fidx/rd_idx index it without width adaptation.
  localparam int unsigned NE = 2**IW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state;
  logic [IW-1:0]     fidx;
  logic              drop_q;
  logic [NF-1:0]     inj_q;
  logic              det_q     [NE];
  logic [N_IN-1:0]   det_pat_q [NE];
  logic              mismatch;
  logic              entry_end;

  assign mismatch  = (z_good != z_fault);
  assign entry_end = (pat == '1) || (drop_q && mismatch);

  assign fault_sa0 = inj_q[N_FAULT-1:0];
`ifdef FAULT_SA1_EN
  assign fault_sa1 = inj_q[NF-1:N_FAULT];
`else
  assign fault_sa1 = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pat       <= '0;
      fidx      <= '0;
      drop_q    <= 1'b0;
      inj_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      det_count <= '0;
      for (int unsigned i = 0; i < NE; i++) begin
        det_q[i]     <= 1'b0;
        det_pat_q[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_RUN;
            busy      <= 1'b1;
            pat       <= '0;
            fidx      <= '0;
            drop_q    <= drop_en;
            inj_q     <= NF'(1);
            det_count <= '0;
            for (int unsigned i = 0; i < NE; i++) begin
              det_q[i]     <= 1'b0;
              det_pat_q[i] <= '0;
            end
          end
        end
        S_RUN: begin
          if (mismatch && !det_q[fidx]) begin
            det_q[fidx]     <= 1'b1;
            det_pat_q[fidx] <= pat;
            det_count       <= det_count + 1'b1;
          end
          if (entry_end) begin
            pat <= '0;
            if (fidx == IW'(NF-1)) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              fidx  <= '0;
              inj_q <= '0;
            end else begin
              fidx  <= fidx + 1'b1;
              inj_q <= NF'(1) << (fidx + 1'b1);
            end
          end else begin
            pat <= pat + 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_det = 1'b0;
    rd_pat = '0;
    if (32'(rd_idx) < NF) begin
      rd_det = det_q[rd_idx];
      rd_pat = det_pat_q[rd_idx];
    end
  end

endmodule

// File: tb/tb_fault_sweep_seq.sv
// Self-checking bench for fault_sweep_seq: fixed CUT scenarios, random detection maps, reset and restart corners.
module tb_fault_sweep_seq;
  localparam int unsigned N_IN = 4;
  localparam int unsigned IW   = 1;
`ifdef FAULT_SA1_EN
  localparam int NF = 2;
`else
  localparam int NF = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          drop_en;
  logic [3:0]    pat;
  logic [0:0]    fault_sa0;
  logic [0:0]    fault_sa1;
  logic [0:0]    z_good;
  logic [0:0]    z_fault;
  logic          busy;
  logic          done;
  logic [1:0]    det_count;
  logic [IW-1:0] rd_idx;
  logic          rd_det;
  logic [3:0]    rd_pat;

  fault_sweep_seq #(.N_IN(4), .N_OUT(1), .N_FAULT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .drop_en(drop_en),
    .pat(pat), .fault_sa0(fault_sa0), .fault_sa1(fault_sa1),
    .z_good(z_good), .z_fault(z_fault), .busy(busy), .done(done),
    .det_count(det_count), .rd_idx(rd_idx), .rd_det(rd_det), .rd_pat(rd_pat)
  );

  always #5 clk = ~clk;

  // CUT: f = A&B, Z = f | (C&D). Mode 0 real fault, 1 undetectable, 2 random detection map.
  int          tb_mode = 0;
  logic [15:0] mism [2];

  always_comb begin
    logic a, b, c, d, f_good, f_bad;
    {a, b, c, d} = pat;
    f_good = a & b;
    f_bad  = f_good;
    if (fault_sa0[0]) f_bad = 1'b0;
    if (fault_sa1[0]) f_bad = 1'b1;
    z_good[0] = f_good | (c & d);
    case (tb_mode)
      0:       z_fault[0] = f_bad | (c & d);
      1:       z_fault[0] = z_good[0];
      default: z_fault[0] = z_good[0] ^
                 ((fault_sa0[0] | fault_sa1[0]) & mism[fault_sa0[0] ? 0 : 1][pat]);
    endcase
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  bit exp_det [2];
  int exp_pat [2];
  int exp_cyc;
  int exp_cnt;

  // Reference: per entry, first detecting pattern; drop shortens detected entries to first+1 cycles.
  task automatic model(input bit drop);
    exp_cyc = 0;
    exp_cnt = 0;
    for (int e = 0; e < 2; e++) begin
      bit found = 0;
      int fp = 0;
      if (e < NF) begin
        for (int p = 0; p < 16; p++)
          if (!found && mism[e][p]) begin found = 1; fp = p; end
        exp_cyc += (drop && found) ? fp + 1 : 16;
        exp_cnt += found ? 1 : 0;
      end
      exp_det[e] = found;
      exp_pat[e] = found ? fp : 0;
    end
  endtask

  task automatic run_sweep(input string tag, input bit drop, input int restart_at, output int cycles);
    start = 1'b1;
    drop_en = drop;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    drop_en = ~drop;
    check({tag, " busy_rise"}, busy, 1);
    check({tag, " first_pat"}, pat, 0);
    check({tag, " first_sa0"}, fault_sa0, 1);
    check({tag, " first_sa1"}, fault_sa1, 0);
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      start = (cycles == restart_at);
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, " busy_fall"}, busy, 0);
    check({tag, " done_pulse"}, done, 1);
    check({tag, " idle_pat"}, pat, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " start_in_done_busy"}, busy, 0);
    check({tag, " done_one_cycle"}, done, 0);
  endtask

  task automatic check_results(input string tag, input int cycles);
    check({tag, " busy_cycles"}, cycles, exp_cyc);
    check({tag, " det_count"}, det_count, exp_cnt);
    for (int i = 0; i < 2; i++) begin
      rd_idx = IW'(i);
      #1;
      check($sformatf("%s rd_det[%0d]", tag, i), rd_det, exp_det[i]);
      check($sformatf("%s rd_pat[%0d]", tag, i), rd_pat, exp_pat[i]);
    end
  endtask

  typedef struct {
    bit drop;
    int mode;
    int restart;
    int cyc;
    int cnt;
    bit det0;
    int pat0;
    bit det1;
    int pat1;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int cycles;
`ifdef FAULT_SA1_EN
    tbl[0] = '{0, 0, 0, 32, 2, 1, 12, 1, 0};
    tbl[1] = '{1, 0, 0, 14, 2, 1, 12, 1, 0};
    tbl[2] = '{1, 1, 0, 32, 0, 0, 0, 0, 0};
    tbl[3] = '{0, 1, 0, 32, 0, 0, 0, 0, 0};
    tbl[4] = '{1, 0, 5, 14, 2, 1, 12, 1, 0};
`else
    tbl[0] = '{0, 0, 0, 16, 1, 1, 12, 0, 0};
    tbl[1] = '{1, 0, 0, 13, 1, 1, 12, 0, 0};
    tbl[2] = '{1, 1, 0, 16, 0, 0, 0, 0, 0};
    tbl[3] = '{0, 1, 0, 16, 0, 0, 0, 0, 0};
    tbl[4] = '{1, 0, 5, 13, 1, 1, 12, 0, 0};
`endif
    rst_n = 1'b0;
    start = 1'b0;
    drop_en = 1'b0;
    rd_idx = '0;
    mism[0] = '0;
    mism[1] = '0;
    repeat (2) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst pat", pat, 0);
    check("rst sa0", fault_sa0, 0);
    check("rst sa1", fault_sa1, 0);
    check("rst det_count", det_count, 0);
    check("rst rd_det", rd_det, 0);
    check("rst rd_pat", rd_pat, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      tb_mode = tbl[v].mode;
      exp_cyc = tbl[v].cyc;
      exp_cnt = tbl[v].cnt;
      exp_det[0] = tbl[v].det0;
      exp_pat[0] = tbl[v].pat0;
      exp_det[1] = tbl[v].det1;
      exp_pat[1] = tbl[v].pat1;
      run_sweep($sformatf("vec%0d", v), tbl[v].drop, tbl[v].restart, cycles);
      check_results($sformatf("vec%0d", v), cycles);
    end

    for (int r = 0; r < 10; r++) begin
      bit drop;
      tb_mode = 2;
      drop = 1'($urandom_range(0, 1));
      for (int e = 0; e < 2; e++)
        for (int p = 0; p < 16; p++)
          mism[e][p] = (r % 4 == 3) ? 1'b0 : ($urandom_range(0, 7) == 0);
      model(drop);
      run_sweep($sformatf("rnd%0d", r), drop, 0, cycles);
      check_results($sformatf("rnd%0d", r), cycles);
    end

    // Asynchronous reset mid-sweep, before and after entry 0 is detected at pattern 12.
    tb_mode = 0;
    for (int t = 0; t < 2; t++) begin
      int target;
      target = (t == 0) ? 5 : 14;
      start = 1'b1;
      drop_en = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 40 && pat != 4'(target); k++) @(negedge clk);
      check($sformatf("rst%0d reached_pat", target), pat, target);
      if (t == 1) check("rst14 pre_det_count", det_count, 1);
      rst_n = 1'b0;
      #1;
      check($sformatf("rst%0d busy", target), busy, 0);
      check($sformatf("rst%0d pat", target), pat, 0);
      check($sformatf("rst%0d sa0", target), fault_sa0, 0);
      check($sformatf("rst%0d det_count", target), det_count, 0);
      rd_idx = '0;
      #1;
      check($sformatf("rst%0d rd_det", target), rd_det, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check($sformatf("rst%0d stays_idle", target), busy, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
